// File: rtl/audio_sample_streamer_pkg.sv
// Shared audio constants and the playback state type, used by the streamer
// and by anything that needs to recognise the mid-scale silence word.
package audio_sample_streamer_pkg;

  localparam logic [31:0] SILENCE_WORD = 32'h0000_8000;

  localparam int CLK_HZ      = 100_000_000;
  localparam int SAMPLE_HZ   = 44_100;
  // Truncated so the output rate sits slightly above 44.1 kHz rather than below.
  localparam int DIV_DEFAULT = CLK_HZ / SAMPLE_HZ;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRIME,
    ST_RUN
  } state_t;

endpackage

// File: rtl/sample_fifo.sv
// Single-clock sample FIFO with registered read data, occupancy count and
// a same-cycle pop-makes-room rule so a full FIFO can still accept a push.
module sample_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty,
  output logic                     dropped
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);
  // A write discarded by flush is intentional, so it is not reported as a drop.
  assign dropped = push && !flush && !do_push;

  // NOTE: the storage array has no reset; only pointers and level define validity,
  // which keeps the array a plain RAM without a reset fan-out to every word.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      rd_data <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr  <= rd_ptr + AW'(1);
        rd_data <= mem[rd_ptr];
      end
      unique case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/audio_sample_streamer.sv
// Buffers processor sample words and releases them as one-cycle strobes at a
// fixed sample rate, priming before playback and emitting silence on underrun.
module audio_sample_streamer
  import audio_sample_streamer_pkg::*;
#(
  parameter int          DEPTH   = 16,
  parameter int          DIV     = DIV_DEFAULT,
  parameter int          PRIME   = 8,
  parameter logic [31:0] SILENCE = SILENCE_WORD
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   flush,
  input  logic                   wr_en,
  input  logic [31:0]            wr_data,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level,
  output logic                   underrun,
  output logic                   overflow,
  input  logic                   err_clr,
  output logic [31:0]            audio_data,
  output logic                   data_valid
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [LW-1:0] PRIME_LVL = LW'(PRIME);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          use_silence;
  logic [31:0]   fifo_rd;
  logic          empty;
  logic          dropped;
  logic          tick;
  logic          pop;

  // Dropping enable overrides a coincident tick, so no sample is consumed then.
  assign tick = enable && (state == ST_RUN) && (cnt == CNT_LAST);
  assign pop  = tick && !empty && !flush;

  // The FIFO read register only changes on a pop, so audio_data holds between strobes.
  assign audio_data = use_silence ? SILENCE : fifo_rd;

  sample_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .push    (wr_en),
    .pop     (pop),
    .wr_data (wr_data),
    .rd_data (fifo_rd),
    .level   (level),
    .full    (full),
    .empty   (empty),
    .dropped (dropped)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      data_valid  <= 1'b0;
      use_silence <= 1'b1;
      underrun    <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      data_valid <= 1'b0;

      // NOTE: non-blocking assignments resolve last-writer-wins, so placing the
      // set after the clear makes a same-cycle error event beat err_clr.
      if (err_clr) begin
        underrun <= 1'b0;
        overflow <= 1'b0;
      end
      if (tick && !pop) begin
        underrun <= 1'b1;
      end
      if (dropped) begin
        overflow <= 1'b1;
      end

      if (!enable) begin
        state <= ST_IDLE;
        cnt   <= '0;
        if (state != ST_IDLE) begin
          data_valid  <= 1'b1;
          use_silence <= 1'b1;
        end
      end else begin
        unique case (state)
          ST_IDLE: begin
            cnt   <= '0;
            state <= ST_PRIME;
          end
          ST_PRIME: begin
            cnt <= '0;
            if (level >= PRIME_LVL) begin
              state <= ST_RUN;
            end
          end
          ST_RUN: begin
            if (tick) begin
              cnt         <= '0;
              data_valid  <= 1'b1;
              use_silence <= !pop;
              if (!pop) begin
                state <= ST_PRIME;
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          default: begin
            cnt   <= '0;
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_audio_sample_streamer.sv
// Directed bench for audio_sample_streamer with DEPTH=4, DIV=4, PRIME=2;
// expected strobe latencies and words are worked out by hand per scenario.
module tb_audio_sample_streamer;

  localparam int          DEPTH = 4;
  localparam int          DIV   = 4;
  localparam int          PRIME = 2;
  localparam logic [31:0] SIL   = 32'h0000_8000;

  logic        clk     = 1'b0;
  logic        reset   = 1'b0;
  logic        enable  = 1'b0;
  logic        flush   = 1'b0;
  logic        wr_en   = 1'b0;
  logic        err_clr = 1'b0;
  logic [31:0] wr_data = '0;

  logic        full;
  logic [2:0]  level;
  logic        underrun;
  logic        overflow;
  logic [31:0] audio_data;
  logic        data_valid;

  int n_checks = 0;
  int n_errors = 0;
  int n;
  bit found;

  audio_sample_streamer #(
    .DEPTH   (DEPTH),
    .DIV     (DIV),
    .PRIME   (PRIME),
    .SILENCE (SIL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .flush      (flush),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .full       (full),
    .level      (level),
    .underrun   (underrun),
    .overflow   (overflow),
    .err_clr    (err_clr),
    .audio_data (audio_data),
    .data_valid (data_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [31:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic wait_strobe(input int max, output int cycles, output bit seen);
    cycles = 0;
    seen   = 1'b0;
    while (!seen && cycles < max) begin
      step();
      cycles++;
      seen = data_valid;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) step();
    check("rst_level",    level,      0);
    check("rst_valid",    data_valid, 0);
    check("rst_audio",    audio_data, SIL);
    check("rst_underrun", underrun,   0);
    check("rst_overflow", overflow,   0);
    check("rst_full",     full,       0);
    reset = 1'b1;
    step();
    check("no_pulse_from_reset", data_valid, 0);

    // Two words, then playback: first strobe 6 cycles after enable rises.
    write(32'h1111);
    check("lvl_after_w1", level, 1);
    write(32'h2222);
    check("lvl_after_w2", level, 2);
    enable = 1'b1;
    wait_strobe(20, n, found);
    check("s1_found", found, 1);
    check("s1_lat",   n, 6);
    check("s1_data",  audio_data, 32'h1111);
    check("s1_level", level, 1);
    step();
    check("s1_pulse_one_cycle", data_valid, 0);
    check("s1_data_held",       audio_data, 32'h1111);
    wait_strobe(20, n, found);
    check("s2_lat",  n, 3);
    check("s2_data", audio_data, 32'h2222);
    wait_strobe(20, n, found);
    check("ur_lat",      n, 4);
    check("ur_data",     audio_data, SIL);
    check("ur_flag",     underrun, 1);
    wait_strobe(12, n, found);
    check("prime_no_strobe", found, 0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("ur_cleared", underrun, 0);
    enable = 1'b0;
    step();
    check("stop_from_prime_valid", data_valid, 1);
    check("stop_from_prime_data",  audio_data, SIL);
    step();
    check("stop_single_pulse", data_valid, 0);

    // Overflow with playback stopped; the fifth write coincides with err_clr.
    write(32'hA1);
    write(32'hA2);
    write(32'hA3);
    write(32'hA4);
    check("ovf_level4", level, 4);
    check("ovf_full",   full, 1);
    check("ovf_pre",    overflow, 0);
    wr_en   = 1'b1;
    wr_data = 32'hA5;
    err_clr = 1'b1;
    step();
    wr_en   = 1'b0;
    err_clr = 1'b0;
    check("ovf_level_kept", level, 4);
    check("ovf_set_wins",   overflow, 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("ovf_cleared", overflow, 0);

    // Full FIFO in RUN: a write on the tick cycle is accepted alongside the pop.
    enable = 1'b1;
    repeat (5) step();
    check("full_pre_tick_valid", data_valid, 0);
    wr_en   = 1'b1;
    wr_data = 32'hB5;
    step();
    wr_en = 1'b0;
    check("full_tick_valid", data_valid, 1);
    check("full_tick_data",  audio_data, 32'hA1);
    check("full_tick_level", level, 4);
    check("full_tick_full",  full, 1);
    check("full_tick_ovf",   overflow, 0);

    // Drop enable mid-RUN: one silence strobe, then nothing, contents retained.
    step();
    step();
    enable = 1'b0;
    step();
    check("stop_run_valid", data_valid, 1);
    check("stop_run_data",  audio_data, SIL);
    wait_strobe(10, n, found);
    check("stop_run_quiet", found, 0);
    check("stop_run_level", level, 4);

    // Resume and drain in order; A5 was dropped, so B5 follows A4.
    enable = 1'b1;
    wait_strobe(20, n, found);
    check("d1_lat",  n, 6);
    check("d1_data", audio_data, 32'hA2);
    wait_strobe(20, n, found);
    check("d2_data", audio_data, 32'hA3);
    wait_strobe(20, n, found);
    check("d3_data", audio_data, 32'hA4);
    wait_strobe(20, n, found);
    check("d4_lat",   n, 4);
    check("d4_data",  audio_data, 32'hB5);
    check("d4_level", level, 0);

    // Queue three words, then flush with a write on the tick cycle.
    write(32'hE1);
    write(32'hE2);
    write(32'hE3);
    check("fl_level3", level, 3);
    flush   = 1'b1;
    wr_en   = 1'b1;
    wr_data = 32'hE4;
    step();
    flush = 1'b0;
    wr_en = 1'b0;
    check("fl_valid",    data_valid, 1);
    check("fl_data",     audio_data, SIL);
    check("fl_underrun", underrun, 1);
    check("fl_level0",   level, 0);
    check("fl_no_ovf",   overflow, 0);

    // From PRIME: RUN starts the cycle after level reaches 2.
    write(32'hC1);
    write(32'hC2);
    write(32'hC3);
    check("c_level3", level, 3);
    wait_strobe(20, n, found);
    check("c1_lat",   n, 4);
    check("c1_data",  audio_data, 32'hC1);
    check("c1_level", level, 2);
    write(32'hC4);
    step();
    step();
    check("rs_pre_level",    level, 3);
    check("rs_pre_underrun", underrun, 1);

    // Reset asserted on what would be a tick cycle.
    reset  = 1'b0;
    enable = 1'b0;
    step();
    check("rs_level",    level, 0);
    check("rs_valid",    data_valid, 0);
    check("rs_audio",    audio_data, SIL);
    check("rs_underrun", underrun, 0);
    check("rs_overflow", overflow, 0);
    check("rs_full",     full, 0);
    reset = 1'b1;
    wait_strobe(10, n, found);
    check("rs_idle_quiet", found, 0);
    check("rs_idle_level", level, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
